// File: rtl/pwm_pkg.sv
// Shared types and default widths for the PWM dead-time generator.
package pwm_pkg;

    localparam int CW_DEF  = 16;
    localparam int DTW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DT_WAIT = 2'd1,
        HIGH_ON = 2'd2,
        LOW_ON  = 2'd3
    } pwm_state_t;

endpackage

// File: rtl/dt_inserter.sv
// Dead-time insertion FSM: turns the registered reference into a
// non-overlapping high/low gate pair with a programmable gap.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   IDLE    | disabled, both gates off
//   DT_WAIT | both gates off, counting dead time toward side 'target'
//   HIGH_ON | high-side gate on
//   LOW_ON  | low-side gate on
module dt_inserter
    import pwm_pkg::*;
#(
    parameter int DTW = DTW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic           ref_q,
    input  logic [DTW-1:0] dt_i,
    output logic           out_h,
    output logic           out_l
);

    pwm_state_t     state;
    pwm_state_t     state_nx;
    logic           target;
    logic           target_nx;
    logic [DTW-1:0] dt_cnt;
    logic [DTW-1:0] dt_cnt_nx;

    always_comb begin
        state_nx  = state;
        target_nx = target;
        dt_cnt_nx = dt_cnt;
        if (!en) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    target_nx = ref_q;
                    dt_cnt_nx = dt_i;
                    state_nx  = DT_WAIT;
                end
                DT_WAIT: begin
                    // a reference bounce restarts the full dead time
                    if (ref_q != target) begin
                        target_nx = ref_q;
                        dt_cnt_nx = dt_i;
                    end else if (dt_cnt == '0) begin
                        state_nx = target ? HIGH_ON : LOW_ON;
                    end else begin
                        dt_cnt_nx = dt_cnt - DTW'(1);
                    end
                end
                HIGH_ON: begin
                    if (!ref_q) begin
                        target_nx = 1'b0;
                        dt_cnt_nx = dt_i;
                        state_nx  = DT_WAIT;
                    end
                end
                LOW_ON: begin
                    if (ref_q) begin
                        target_nx = 1'b1;
                        dt_cnt_nx = dt_i;
                        state_nx  = DT_WAIT;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Gate drives come from the current state only, so they can never overlap;
    // en gates them directly so disabling clears them on the very next edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            target <= 1'b0;
            dt_cnt <= '0;
            out_h  <= 1'b0;
            out_l  <= 1'b0;
        end else begin
            state  <= state_nx;
            target <= target_nx;
            dt_cnt <= dt_cnt_nx;
            out_h  <= en && (state == HIGH_ON);
            out_l  <= en && (state == LOW_ON);
        end
    end

endmodule

// File: rtl/pwm_deadtime_gen.sv
// Complementary PWM generator: double-buffered compare promoted at period
// boundaries, registered reference, and dead-time insertion.
module pwm_deadtime_gen
    import pwm_pkg::*;
#(
    parameter int CW  = CW_DEF,
    parameter int DTW = DTW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           en,
    input  logic [CW-1:0]  counter_i,
    input  logic           done_i,
    input  logic [CW-1:0]  cmp_i,
    input  logic           cmp_wr,
    input  logic [DTW-1:0] dt_i,
    input  logic           pol_i,
    output logic           out_h,
    output logic           out_l,
    output logic [CW-1:0]  cmp_active,
    output logic           update_pulse
);

    logic [CW-1:0] shadow;
    logic          pending;
    logic          ref_q;
    logic          promote;

    assign promote = done_i && pending;

    // A write coinciding with a promotion lands in the shadow and stays pending.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow       <= '0;
            pending      <= 1'b0;
            cmp_active   <= '0;
            update_pulse <= 1'b0;
            ref_q        <= 1'b0;
        end else begin
            update_pulse <= promote;
            if (promote) begin
                cmp_active <= shadow;
            end
            if (cmp_wr) begin
                shadow  <= cmp_i;
                pending <= 1'b1;
            end else if (promote) begin
                pending <= 1'b0;
            end
            ref_q <= (counter_i < cmp_active) ^ pol_i;
        end
    end

    dt_inserter #(
        .DTW (DTW)
    ) u_dt (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .ref_q (ref_q),
        .dt_i  (dt_i),
        .out_h (out_h),
        .out_l (out_l)
    );

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: compare buffering table, PWM sweeps,
// dead-time restart, enable abort and asynchronous reset.
module tb_pwm_deadtime_gen;

    logic        clk;
    logic        reset;
    logic        en;
    logic [15:0] counter_i;
    logic        done_i;
    logic [15:0] cmp_i;
    logic        cmp_wr;
    logic [7:0]  dt_i;
    logic        pol_i;
    logic        out_h;
    logic        out_l;
    logic [15:0] cmp_active;
    logic        update_pulse;

    int total = 0;
    int bad   = 0;
    int cnt   = 10;

    pwm_deadtime_gen #(.CW(16), .DTW(8)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .en           (en),
        .counter_i    (counter_i),
        .done_i       (done_i),
        .cmp_i        (cmp_i),
        .cmp_wr       (cmp_wr),
        .dt_i         (dt_i),
        .pol_i        (pol_i),
        .out_h        (out_h),
        .out_l        (out_l),
        .cmp_active   (cmp_active),
        .update_pulse (update_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wr;
        logic [15:0] cmp;
        logic        done;
        logic [15:0] exp_act;
        logic        exp_upd;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic eh, input logic el);
        chk({name, "_h"}, 32'(out_h), 32'(eh));
        chk({name, "_l"}, 32'(out_l), 32'(el));
    endtask

    // Steady-state gate pattern for cmp=4, dt=2, keyed by the counter value
    // sampled on the edge just before the check.
    logic [10:0] pat_h;
    logic [10:0] pat_l;

    // mode: 0 no check, 1 normal pattern, 2 swapped, 3 low steady, 4 high steady
    task automatic sweep(input int periods, input int mode, input logic wr, input logic [15:0] newcmp);
        logic eh, el;
        for (int i = 0; i < periods * 11; i++) begin
            counter_i = 16'(cnt);
            done_i    = (cnt == 0);
            cmp_wr    = wr && (i == 0);
            cmp_i     = newcmp;
            tick();
            eh = 1'b0;
            el = 1'b0;
            case (mode)
                1: begin eh = pat_h[cnt]; el = pat_l[cnt]; end
                2: begin eh = pat_l[cnt]; el = pat_h[cnt]; end
                3: el = 1'b1;
                4: eh = 1'b1;
                default: ;
            endcase
            if (mode != 0) chk_out($sformatf("sweep_m%0d_c%0d", mode, cnt), eh, el);
            cnt = (cnt == 0) ? 10 : cnt - 1;
        end
        done_i = 1'b0;
        cmp_wr = 1'b0;
    endtask

    always @(negedge clk) begin
        total++;
        if (out_h && out_l) begin
            bad++;
            $display("FAIL overlap: out_h=%0d out_l=%0d at %0t", out_h, out_l, $time);
        end
    end

    initial begin
        pat_h = 11'b010_0000_0000;
        pat_l = 11'b000_0011_1100;

        //          wr   cmp    done  act    upd
        vecs[0]  = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0};
        vecs[1]  = '{1'b1, 16'd4, 1'b0, 16'd0, 1'b0};
        vecs[2]  = '{1'b0, 16'd0, 1'b0, 16'd0, 1'b0};
        vecs[3]  = '{1'b0, 16'd0, 1'b1, 16'd4, 1'b1};
        vecs[4]  = '{1'b0, 16'd0, 1'b0, 16'd4, 1'b0};
        vecs[5]  = '{1'b0, 16'd0, 1'b1, 16'd4, 1'b0};
        vecs[6]  = '{1'b1, 16'd3, 1'b0, 16'd4, 1'b0};
        vecs[7]  = '{1'b1, 16'd7, 1'b1, 16'd3, 1'b1};
        vecs[8]  = '{1'b0, 16'd0, 1'b0, 16'd3, 1'b0};
        vecs[9]  = '{1'b0, 16'd0, 1'b1, 16'd7, 1'b1};
        vecs[10] = '{1'b0, 16'd0, 1'b1, 16'd7, 1'b0};
        vecs[11] = '{1'b1, 16'd9, 1'b1, 16'd7, 1'b0};
        vecs[12] = '{1'b0, 16'd0, 1'b1, 16'd9, 1'b1};

        reset     = 1'b0;
        en        = 1'b0;
        counter_i = 16'd10;
        done_i    = 1'b0;
        cmp_i     = 16'd0;
        cmp_wr    = 1'b0;
        dt_i      = 8'd2;
        pol_i     = 1'b0;

        #12;
        chk_out("in_reset", 1'b0, 1'b0);
        chk("in_reset_act", 32'(cmp_active), 32'd0);
        chk("in_reset_upd", 32'(update_pulse), 32'd0);
        #10 reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            cmp_wr = vecs[i].wr;
            cmp_i  = vecs[i].cmp;
            done_i = vecs[i].done;
            tick();
            chk($sformatf("vec%0d_act", i), 32'(cmp_active), 32'(vecs[i].exp_act));
            chk($sformatf("vec%0d_upd", i), 32'(update_pulse), 32'(vecs[i].exp_upd));
            chk_out($sformatf("vec%0d_idle", i), 1'b0, 1'b0);
        end
        cmp_wr = 1'b0;
        done_i = 1'b0;

        en = 1'b1;
        sweep(3, 0, 1'b1, 16'd4);
        chk("pwm_act", 32'(cmp_active), 32'd4);
        sweep(2, 1, 1'b0, 16'd0);

        pol_i = 1'b1;
        sweep(2, 0, 1'b0, 16'd0);
        sweep(2, 2, 1'b0, 16'd0);
        pol_i = 1'b0;

        sweep(3, 0, 1'b1, 16'd0);
        sweep(1, 3, 1'b0, 16'd0);

        sweep(3, 0, 1'b1, 16'd11);
        sweep(1, 4, 1'b0, 16'd0);

        // write with done while nothing pending: active holds, next done promotes
        counter_i = 16'd10;
        cmp_i     = 16'd4;
        cmp_wr    = 1'b1;
        done_i    = 1'b1;
        tick();
        chk("simul_nopend_act", 32'(cmp_active), 32'd11);
        cmp_wr = 1'b0;
        tick();
        chk("simul_nopend_promote", 32'(cmp_active), 32'd4);
        done_i = 1'b0;
        dt_i   = 8'd5;
        repeat (16) tick();
        chk_out("glitch_pre", 1'b0, 1'b1);

        counter_i = 16'd0;
        tick();
        chk_out("glitch_e0", 1'b0, 1'b1);
        tick();
        chk_out("glitch_e1", 1'b0, 1'b1);
        counter_i = 16'd10;
        tick();
        chk_out("glitch_e2", 1'b0, 1'b0);
        for (int k = 3; k <= 9; k++) begin
            tick();
            chk_out($sformatf("glitch_e%0d", k), 1'b0, 1'b0);
        end
        tick();
        chk_out("glitch_e10", 1'b0, 1'b1);

        dt_i      = 8'd2;
        counter_i = 16'd0;
        repeat (10) tick();
        chk_out("abort_pre", 1'b1, 1'b0);
        en = 1'b0;
        tick();
        chk_out("abort_next", 1'b0, 1'b0);
        chk("abort_state", 32'(u_dut.u_dt.state), 32'(pwm_pkg::IDLE));
        tick();
        chk_out("abort_hold", 1'b0, 1'b0);
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk_out($sformatf("reen_t%0d", k), 1'b0, 1'b0);
        end
        tick();
        chk_out("reen_t5", 1'b1, 1'b0);

        #2 reset = 1'b0;
        #1;
        chk_out("async_reset", 1'b0, 1'b0);
        chk("async_reset_act", 32'(cmp_active), 32'd0);
        tick();
        chk_out("reset_hold", 1'b0, 1'b0);
        reset = 1'b1;
        tick();
        chk("post_reset_upd", 32'(update_pulse), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_deadtime_gen.md
Name: pwm_deadtime_gen

Overview:
- Downstream consumer of the prescaled down counter: takes its live `counter` value and its `done` reload pulse, and produces a complementary PWM pair with programmable dead time.
- Holds a double-buffered compare register; the buffered value is promoted to the active compare only at period boundaries.
- Sits between the timer core and the power-stage gate outputs.

Parameters:
- CW, 16, counter/compare width; matches the down counter's `counter`/`reload` width.
- DTW, 8, dead-time counter width in clk cycles.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  enable; 0 forces both outputs low and the FSM to IDLE
- counter_i  in  CW  live value from the down counter
- done_i  in  1  one-cycle pulse from the down counter at reload (period boundary)
- cmp_i  in  CW  new compare value
- cmp_wr  in  1  write strobe: cmp_i -> shadow register
- dt_i  in  DTW  dead time in clk cycles
- pol_i  in  1  1 = invert the reference waveform before dead-time insertion
- out_h  out  1  high-side gate drive
- out_l  out  1  low-side gate drive
- cmp_active  out  CW  compare value currently in use
- update_pulse  out  1  one-cycle pulse when the shadow value is transferred to active

Behaviour:
- Reset (reset=0, async): out_h=0, out_l=0, cmp_active=0, shadow=0, pending=0, update_pulse=0, ref_q=0, FSM=IDLE, dt_cnt=0.
- Shadow register:
  - cmp_wr=1 -> shadow<=cmp_i and pending<=1.
  - done_i=1 with pending=1 -> cmp_active<=shadow, pending<=0, update_pulse=1 on the next cycle.
- Simultaneous cmp_wr and done_i:
  - If pending was 1, the old shadow goes to active, the new value is stored in shadow, and pending stays 1.
  - If pending was 0, active is unchanged, shadow gets the new value, and pending=1.
- Reference:
  - ref_q <= (counter_i < cmp_active) XOR pol_i; registered, 1 cycle latency.
  - Compare is unsigned over the full CW width.
  - cmp_active=0 gives 0% duty (ref=pol_i).
  - cmp_active > reload gives 100% duty.
- FSM states: IDLE, DT_WAIT, HIGH_ON, LOW_ON.
  - IDLE: both outputs 0. When en=1: target<=ref_q, dt_cnt<=dt_i, go to DT_WAIT.
  - DT_WAIT: both outputs 0.
    - If ref_q != target: target<=ref_q and dt_cnt<=dt_i (restart).
    - Else if dt_cnt==0: go to HIGH_ON if target=1, else LOW_ON.
    - Else dt_cnt decrements.
  - HIGH_ON: out_h=1, out_l=0. On ref_q=0: go to DT_WAIT with target=0, dt_cnt=dt_i.
  - LOW_ON: out_l=1, out_h=0. On ref_q=1: go to DT_WAIT with target=1, dt_cnt=dt_i.
  - dt_i=0: DT_WAIT lasts exactly 1 cycle with both outputs low. The minimum gap is 1 cycle; this is a safety guarantee.
- Outputs are registered and decoded from the state. out_h and out_l are never both 1 in any cycle, including reset and en transitions.
- Latency with dt_i=N: from the counter_i sample crossing the compare to the new side asserting is 2+N+1 cycles. The opposite side drops 2 cycles after the crossing.
- en=0 in any state: next cycle both outputs are 0 and FSM=IDLE. Shadow, active and pending logic keep running.
- dt_i changes take effect on the next load of dt_cnt only.
- Reset mid-operation: everything returns immediately to reset values; no glitch on the outputs (async clear of the output flops).

Decomposition:
- Shared package pwm_pkg:
  - typedef enum logic [1:0] pwm_state_t {IDLE, DT_WAIT, HIGH_ON, LOW_ON}
  - localparams CW_DEF=16, DTW_DEF=8
- One natural sub-module, dt_inserter: takes ref_q, dt_i and en; produces out_h/out_l and holds the FSM and dt_cnt.
- The top level keeps shadow/active/pending and the comparator.

Test Plan:
- Reset/idle: hold reset=0 for 20 ns, then release with en=0 -> out_h=out_l=0, cmp_active=0, update_pulse=0 throughout.
- Shadow update: write cmp_i=4 mid-period, then pulse done_i -> cmp_active=4 the cycle after done_i, update_pulse high for exactly 1 cycle, no change before done_i.
- PWM with dead time:
  - Setup: counter_i sweeps 10..0 at 1 count/cycle with done_i at the reload, cmp_active=4, dt_i=2, pol_i=0, en=1.
  - Required: out_h high for counter<4 (shifted 2 cycles); on each edge both outputs low for exactly 3 cycles (the dt_cnt 2->1->0 cycles plus the transition cycle) before the opposite side asserts.
  - Required: the assertion out_h&out_l==0 holds every cycle.
- Glitch restart: during DT_WAIT (dt_i=5), toggle the reference back after 2 cycles -> dt_cnt restarts, no output asserts until 6 stable cycles have elapsed.
- Boundaries:
  - cmp_active=0 -> out_l steady high and out_h never asserts.
  - cmp_active=11 with reload=10 -> out_h steady high.
  - pol_i=1 with cmp_active=4 -> high/low roles swapped.
- Simultaneous and abort:
  - cmp_wr(7) in the same cycle as done_i with pending=1 (shadow=3) -> active=3, shadow=7, pending=1; the next done_i gives active=7.
  - Deassert en while in HIGH_ON -> both outputs 0 next cycle, FSM=IDLE.
